// File: rtl/alu_lock_mgr.sv
// alu_lock_mgr: arbitrates exclusive ownership of a shared ALU between sub-issue cores by oldest issue id.
// Optional hold watchdog compiled in with ALU_LOCK_WATCHDOG_EN.
module alu_lock_mgr #(
  parameter int NUM_SIC     = 4,
  parameter int ID_WIDTH    = 6,
  parameter int WDOG_CYCLES = 64
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_SIC-1:0]                 req,
  input  logic [NUM_SIC-1:0][ID_WIDTH-1:0]   req_issue_id,
  input  logic [NUM_SIC-1:0]                 release_lock,
  input  logic [NUM_SIC-1:0][3:0]            alu_op,
  input  logic [NUM_SIC-1:0][31:0]           alu_a,
  input  logic [NUM_SIC-1:0][31:0]           alu_b,
  output logic [NUM_SIC-1:0]                 alu_grant,
  output logic [31:0]                        alu_c,
  output logic                               alu_zero,
  output logic                               wdog_err
);
  localparam int OW = $clog2(NUM_SIC);
  logic              locked;
  logic [OW-1:0]     owner;
  logic [OW-1:0]     win;
  logic [NUM_SIC-1:0] cand;
  logic              any;
  logic              rel;
  logic [3:0]        op;
  logic [31:0]       a;
  logic [31:0]       b;
  logic [31:0]       c;

  // wrap-aware age compare: x is older when (x - y) has its MSB set
  function automatic logic older(input logic [ID_WIDTH-1:0] x, input logic [ID_WIDTH-1:0] y);
    logic [ID_WIDTH-1:0] d;
    d = x - y;
    return d[ID_WIDTH-1];
  endfunction

  always_comb begin
    rel  = locked && release_lock[owner];
    cand = req & ~(locked ? (NUM_SIC'(1) << owner) : '0);
    any  = |cand;
    win  = '0;
    for (int i = 1; i < NUM_SIC; i++)
      if (cand[i] && (!cand[win] || older(req_issue_id[i], req_issue_id[win])))
        win = OW'(i);
  end

`ifdef ALU_LOCK_WATCHDOG_EN
  localparam int CW = $clog2(WDOG_CYCLES + 1);
  logic [CW-1:0] hold;
  logic          expire;
  assign expire = locked && !rel && hold == CW'(WDOG_CYCLES - 1);

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      hold     <= '0;
      wdog_err <= 1'b0;
    end else if (!locked || rel || expire) begin
      hold     <= '0;
      wdog_err <= wdog_err | expire;
    end else
      hold <= hold + 1'b1;
`else
  logic expire;
  assign expire   = 1'b0;
  assign wdog_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      locked <= 1'b0;
      owner  <= '0;
    end else if (!locked || rel) begin
      locked <= any;
      if (any) owner <= win;
    end else if (expire)
      locked <= 1'b0;

  for (genvar g = 0; g < NUM_SIC; g++) begin : g_grant
    assign alu_grant[g] = locked && owner == OW'(g);
  end

  assign op = alu_op[owner];
  assign a  = alu_a[owner];
  assign b  = alu_b[owner];

  always_comb
    case (op)
      4'd0:    c = a + b;
      4'd1:    c = a - b;
      4'd2:    c = a & b;
      4'd3:    c = a | b;
      4'd4:    c = a ^ b;
      4'd5:    c = ~(a | b);
      4'd6:    c = {31'd0, $signed(a) < $signed(b)};
      4'd7:    c = {31'd0, a < b};
      4'd8:    c = {b[15:0], 16'd0};
      default: c = '0;
    endcase

  assign alu_c    = locked ? c : '0;
  assign alu_zero = alu_c == '0;
endmodule

// File: tb/tb_alu_lock_mgr.sv
// tb_alu_lock_mgr: directed and randomized checks of alu_lock_mgr against an age-ordered reference model.
module tb_alu_lock_mgr;
  localparam int N  = 4;
  localparam int IW = 6;
  localparam int WD = 8;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [N-1:0]           req, release_lock, alu_grant;
  logic [N-1:0][IW-1:0]   req_issue_id;
  logic [N-1:0][3:0]      alu_op;
  logic [N-1:0][31:0]     alu_a, alu_b;
  logic [31:0]            alu_c;
  logic                   alu_zero, wdog_err;

  int errors = 0;
  int checks = 0;

  bit m_locked;
  int m_owner;
  int m_hold;
  bit m_err;
  int base;
  int off [N];

  alu_lock_mgr #(.NUM_SIC(N), .ID_WIDTH(IW), .WDOG_CYCLES(WD)) dut (
    .clk(clk), .rst(rst), .req(req), .req_issue_id(req_issue_id),
    .release_lock(release_lock), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_grant(alu_grant), .alu_c(alu_c), .alu_zero(alu_zero), .wdog_err(wdog_err)
  );

  always #5 clk = ~clk;

  // ids are base + small offset, so "oldest" is simply the smallest offset
  task automatic set_ids();
    for (int i = 0; i < N; i++) req_issue_id[i] = IW'(base + off[i]);
  endtask

  function automatic int pick(input logic [N-1:0] m);
    int best = -1;
    for (int i = 0; i < N; i++)
      if (m[i] && (best < 0 || off[i] < off[best])) best = i;
    return best;
  endfunction

  function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return ~(a | b);
      4'd6: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      4'd7: return (a < b) ? 32'd1 : 32'd0;
      4'd8: return b << 16;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [N-1:0] exp_grant();
    return m_locked ? N'(1) << m_owner : '0;
  endfunction

  function automatic logic [31:0] exp_c();
    return m_locked ? alu_ref(alu_op[m_owner], alu_a[m_owner], alu_b[m_owner]) : 32'd0;
  endfunction

  task automatic tick();
    int w;
    logic [N-1:0] m;
    if (!m_locked) begin
      w = pick(req);
      if (w >= 0) begin m_locked = 1; m_owner = w; m_hold = 0; end
    end else if (release_lock[m_owner]) begin
      m = req;
      m[m_owner] = 1'b0;
      w = pick(m);
      if (w >= 0) begin m_owner = w; m_hold = 0; end
      else m_locked = 0;
    end
`ifdef ALU_LOCK_WATCHDOG_EN
    else begin
      m_hold++;
      if (m_hold == WD) begin m_locked = 0; m_err = 1; end
    end
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req = '0; release_lock = '0; alu_op = '0; alu_a = '0; alu_b = '0;
    base = 0;
    for (int i = 0; i < N; i++) off[i] = i;
    set_ids();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    m_locked = 0; m_owner = 0; m_hold = 0; m_err = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_inputs();
  endtask

  task automatic test_reset();
    clear_inputs();
    req = '1;
    rst = 1'b1;
    m_locked = 0; m_owner = 0; m_hold = 0; m_err = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (alu_grant !== '0) begin errors++; $display("FAIL reset_grant got=%b exp=0000", alu_grant); end
    checks++; if (alu_c !== 32'd0) begin errors++; $display("FAIL reset_c got=%h exp=0", alu_c); end
    checks++; if (alu_zero !== 1'b1) begin errors++; $display("FAIL reset_zero got=%b exp=1", alu_zero); end
    checks++; if (wdog_err !== 1'b0) begin errors++; $display("FAIL reset_wdog got=%b exp=0", wdog_err); end
    rst = 1'b0;
    req = '0;
  endtask

  task automatic test_basic_arb();
    do_reset();
    base = 3; off[1] = 2; off[2] = 0; off[0] = 9; off[3] = 9;
    set_ids();
    req = 4'b0110;
    tick();
    checks++; if (alu_grant !== 4'b0100) begin errors++; $display("FAIL basic_arb got=%b exp=0100", alu_grant); end
  endtask

  task automatic test_wrap();
    do_reset();
    base = 62; off[0] = 0; off[3] = 3; off[1] = 20; off[2] = 20;
    set_ids();
    req = 4'b1001;
    tick();
    checks++; if (alu_grant !== 4'b0001) begin errors++; $display("FAIL wrap_arb got=%b exp=0001", alu_grant); end
  endtask

  task automatic test_handoff();
    do_reset();
    req = 4'b0100;
    tick();
    checks++; if (alu_grant !== 4'b0100) begin errors++; $display("FAIL handoff_own got=%b exp=0100", alu_grant); end
    base = 7; off[0] = 0; off[3] = 2; off[1] = 30; off[2] = 30;
    set_ids();
    req = 4'b1001;
    release_lock = 4'b0100;
    tick();
    release_lock = '0;
    checks++; if (alu_grant !== 4'b0001) begin errors++; $display("FAIL handoff_move got=%b exp=0001", alu_grant); end
    checks++; if (alu_grant !== exp_grant()) begin errors++; $display("FAIL handoff_model got=%b exp=%b", alu_grant, exp_grant()); end
  endtask

  task automatic test_nonowner_release_alu();
    do_reset();
    req = 4'b0010;
    tick();
    req = '0;
    release_lock = 4'b1000;
    tick();
    release_lock = '0;
    checks++; if (alu_grant !== 4'b0010) begin errors++; $display("FAIL foreign_release got=%b exp=0010", alu_grant); end
    tick();
    checks++; if (alu_grant !== 4'b0010) begin errors++; $display("FAIL hold_no_req got=%b exp=0010", alu_grant); end
    alu_op[1] = 4'd1; alu_a[1] = 32'd5; alu_b[1] = 32'd5;
    #1;
    checks++; if (alu_c !== 32'd0) begin errors++; $display("FAIL subu_c got=%h exp=0", alu_c); end
    checks++; if (alu_zero !== 1'b1) begin errors++; $display("FAIL subu_zero got=%b exp=1", alu_zero); end
    alu_op[1] = 4'd6; alu_a[1] = 32'hFFFF_FFFF; alu_b[1] = 32'd1;
    #1;
    checks++; if (alu_c !== 32'd1) begin errors++; $display("FAIL slt_c got=%h exp=1", alu_c); end
    checks++; if (alu_zero !== 1'b0) begin errors++; $display("FAIL slt_zero got=%b exp=0", alu_zero); end
    alu_op[1] = 4'd8; alu_b[1] = 32'hDEAD_1234;
    #1;
    checks++; if (alu_c !== 32'h1234_0000) begin errors++; $display("FAIL lui_c got=%h exp=12340000", alu_c); end
  endtask

  task automatic test_async_reset();
    do_reset();
    req = 4'b0001;
    tick();
    checks++; if (alu_grant !== 4'b0001) begin errors++; $display("FAIL pre_rst_own got=%b exp=0001", alu_grant); end
    #2;
    rst = 1'b1;
    m_locked = 0; m_owner = 0; m_hold = 0; m_err = 0;
    #1;
    checks++; if (alu_grant !== '0) begin errors++; $display("FAIL async_rst got=%b exp=0000", alu_grant); end
    rst = 1'b0;
    tick();
    checks++; if (alu_grant !== 4'b0001) begin errors++; $display("FAIL post_rst got=%b exp=0001", alu_grant); end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 600; n++) begin
      base = int'($urandom_range(0, 63));
      for (int i = 0; i < N; i++) begin
        off[i]    = int'($urandom_range(0, 31));
        alu_op[i] = 4'($urandom_range(0, 15));
        alu_a[i]  = $urandom;
        alu_b[i]  = ($urandom_range(0, 3) == 0) ? alu_a[i] : $urandom;
      end
      set_ids();
      req = N'($urandom);
      release_lock = ($urandom_range(0, 2) == 0 && m_locked) ? N'(1) << m_owner : N'($urandom & $urandom & $urandom);
      tick();
      checks++; if (alu_grant !== exp_grant()) begin errors++; $display("FAIL rnd_grant n=%0d got=%b exp=%b", n, alu_grant, exp_grant()); end
      checks++; if (alu_c !== exp_c()) begin errors++; $display("FAIL rnd_c n=%0d got=%h exp=%h", n, alu_c, exp_c()); end
      checks++; if (alu_zero !== (exp_c() == 32'd0)) begin errors++; $display("FAIL rnd_zero n=%0d got=%b exp=%b", n, alu_zero, exp_c() == 32'd0); end
      checks++; if (wdog_err !== m_err) begin errors++; $display("FAIL rnd_wdog n=%0d got=%b exp=%b", n, wdog_err, m_err); end
    end
    release_lock = '0;
  endtask

  task automatic test_watchdog();
    do_reset();
    req = 4'b0001;
    tick();
    req = '0;
    for (int n = 0; n < 120; n++) begin
      tick();
      checks++; if (alu_grant !== exp_grant()) begin errors++; $display("FAIL wdog_grant n=%0d got=%b exp=%b", n, alu_grant, exp_grant()); end
      checks++; if (wdog_err !== m_err) begin errors++; $display("FAIL wdog_err n=%0d got=%b exp=%b", n, wdog_err, m_err); end
    end
`ifdef ALU_LOCK_WATCHDOG_EN
    checks++; if (wdog_err !== 1'b1 || alu_grant !== '0) begin errors++; $display("FAIL wdog_final err=%b grant=%b exp err=1 grant=0000", wdog_err, alu_grant); end
`else
    checks++; if (wdog_err !== 1'b0 || alu_grant !== 4'b0001) begin errors++; $display("FAIL wdog_final err=%b grant=%b exp err=0 grant=0001", wdog_err, alu_grant); end
`endif
  endtask

  initial begin
    test_reset();
    test_basic_arb();
    test_wrap();
    test_handoff();
    test_nonowner_release_alu();
    test_async_reset();
    test_random();
    test_watchdog();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/alu_lock_mgr.md
ALU_LOCK_MGR -- requirements
Module: alu_lock_mgr

Interface
REQ-001 Parameter NUM_SIC, default 4, number of requesting sub-issue cores (2..8).
REQ-002 Parameter ID_WIDTH, default 6, issue-id width.
REQ-003 Parameter WDOG_CYCLES, default 64, watchdog limit; used only under ALU_LOCK_WATCHDOG_EN.
REQ-004 clk  input  1  single clock, rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 req  input  NUM_SIC  per-SIC lock request, level.
REQ-007 req_issue_id  input  NUM_SIC x ID_WIDTH  issue id of each requester.
REQ-008 release_lock  input  NUM_SIC  one-cycle release pulse per SIC.
REQ-009 alu_op  input  NUM_SIC x 4  ALU opcode per SIC.
REQ-010 alu_a, alu_b  input  NUM_SIC x 32 each  ALU operands per SIC.
REQ-011 alu_grant  output  NUM_SIC  one-hot-or-zero grant.
REQ-012 alu_c  output  32  result of owner's operation, broadcast.
REQ-013 alu_zero  output  1  alu_c == 0.
REQ-014 wdog_err  output  1  sticky watchdog error (0 when watchdog compiled out).

Function
REQ-015 State: locked (1 bit), owner (index); alu_grant[i] = locked && owner == i, from registers only.
REQ-016 Arbitration winner: among req[i]=1, the oldest issue id; x older than y iff MSB of (x - y) mod 2^ID_WIDTH is 1; equal ids -> lowest index.
REQ-017 Lock free, any req high in cycle t -> locked=1, owner=winner at edge ending t; grant visible cycle t+1.
REQ-018 Owner holds lock regardless of its req level until release_lock[owner] pulses.
REQ-019 release_lock[owner] in cycle t: if any other req high, owner=winner among requesters excluding the releaser, locked stays 1 (grant moves in cycle t+1); else locked=0.
REQ-020 release_lock from a non-owner, or while unlocked, is ignored.
REQ-021 Requests arriving while locked wait; no preemption by an older id.
REQ-022 ALU: combinational on owner's alu_op/alu_a/alu_b; ops 0 ADDU, 1 SUBU, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLT (signed), 7 SLTU, 8 LUI (b[15:0]<<16), others -> 0; results mod 2^32.
REQ-023 alu_c/alu_zero valid only while any alu_grant is high; when unlocked alu_c = 0, alu_zero = 1.

Reset
REQ-024 rst asserted (any time, including mid-lock): locked=0, owner=0, alu_grant=0, wdog_err=0, hold counter 0, immediately.
REQ-025 First arbitration occurs at the first edge after rst deasserts.

Configuration
REQ-026 Macro ALU_LOCK_WATCHDOG_EN defined: a hold counter clears on each new grant and increments each locked cycle; reaching WDOG_CYCLES with no release forces locked=0 and sets wdog_err, sticky until rst.
REQ-027 ALU_LOCK_WATCHDOG_EN undefined: no counter, lock held indefinitely, wdog_err tied 0.

Verification
REQ-028 Unlocked, req=0b0110, ids SIC1=5, SIC2=3 in cycle t -> alu_grant=0b0100 in cycle t+1.
REQ-029 ID_WIDTH=6, SIC0 id=62, SIC3 id=1 both requesting -> SIC0 granted (wrap-around older).
REQ-030 SIC2 owns; release_lock[2] pulse with req=0b1001 and ids 7, 9 -> grant 0b0001 next cycle, no idle cycle.
REQ-031 SIC1 owns; release_lock[3] pulse -> grant stays 0b0010; then SIC1 op SUBU a=5 b=5 -> alu_c=0, alu_zero=1; op SLT a=0xFFFFFFFF b=1 -> alu_c=1.
REQ-032 rst pulse while SIC0 owns -> alu_grant=0 asynchronously; after deassert with req=0b0001 -> grant 0b0001 one cycle later.
REQ-033 With ALU_LOCK_WATCHDOG_EN, WDOG_CYCLES=8, owner never releases -> lock dropped and wdog_err=1 after 8 locked cycles; without the macro grant persists beyond 100 cycles.
